cms_trace_stream_arbiter: RTL

- Shares one AXI-Stream DMA channel between two continuous-monitoring trace sources (two monitored cores), each of which emits trace packets terminated by tlast.
- Grants whole packets, alternates grants round-robin at packet boundaries, never breaks AXI-Stream valid/data stability rules, and keeps per-source beat/packet statistics plus a sticky mid-packet stall flag.
- Sits between the monitoring blocks' M_AXIS outputs and the AXI DMA S2MM port.

---
 rtl/cms_trace_stream_arbiter_if.sv | 19 +
 rtl/cms_trace_stream_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cms_trace_stream_arbiter_if.sv
// AXI-Stream bundle shared by the two trace sources and the merged DMA output.
// master: the side that drives tvalid/tdata/tlast; slave: the side that drives tready.
// Optional source-id sideband on the merged stream: CMS_ARB_SOURCE_ID_TUSER_EN.
interface cms_trace_stream_arbiter_if #(
  parameter int DATA_WIDTH = 1024
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
`ifdef CMS_ARB_SOURCE_ID_TUSER_EN
  logic                  tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
`else
  modport master (output tvalid, output tdata, output tlast, input tready);
`endif
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/cms_trace_stream_arbiter.sv
// Packet-atomic round-robin arbiter merging two trace AXI-Stream sources onto one
// DMA S2MM stream. Datapath is a pure combinational mux through the granted source;
// the grant only moves at packet boundaries, and never while a beat is offered
// but not yet accepted. Keeps saturating per-source beat/packet counts and a sticky
// mid-packet stall flag.
// Optional feature macro: CMS_ARB_SOURCE_ID_TUSER_EN (adds m.tuser = granted index).
module cms_trace_stream_arbiter #(
  parameter int DATA_WIDTH    = 1024,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cms_trace_stream_arbiter_if.slave  s0,
  cms_trace_stream_arbiter_if.slave  s1,
  cms_trace_stream_arbiter_if.master m,
  input  logic                 clear_stats,
  output logic [1:0]           grant,
  output logic [CNT_WIDTH-1:0] beats0,
  output logic [CNT_WIDTH-1:0] beats1,
  output logic [CNT_WIDTH-1:0] pkts0,
  output logic [CNT_WIDTH-1:0] pkts1,
  output logic                 stall_error
);

  // State encoding doubles as the one-hot grant output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_next;
  state_t w_other_state;
  logic   r_last_served;
  logic   w_last_served_next;
  logic   r_in_packet;
  logic   w_in_packet_next;

  logic w_g0;
  logic w_g1;
  logic w_cur_valid;
  logic w_oth_valid;
  logic w_accept;
  logic w_eop;

  assign w_g0 = (r_state == ST_GNT0);
  assign w_g1 = (r_state == ST_GNT1);

  // Datapath: only the granted source reaches the output, so a non-granted
  // source's garbage can never leak onto m.*.
  assign m.tvalid  = (w_g0 & s0.tvalid) | (w_g1 & s1.tvalid);
  assign m.tdata   = w_g0 ? s0.tdata : (w_g1 ? s1.tdata : '0);
  assign m.tlast   = (w_g0 & s0.tlast) | (w_g1 & s1.tlast);
  assign s0.tready = w_g0 & m.tready;
  assign s1.tready = w_g1 & m.tready;
`ifdef CMS_ARB_SOURCE_ID_TUSER_EN
  assign m.tuser   = w_g1;
`endif

  assign w_accept      = m.tvalid & m.tready;
  assign w_eop         = w_accept & m.tlast;
  assign w_cur_valid   = w_g0 ? s0.tvalid : s1.tvalid;
  assign w_oth_valid   = w_g0 ? s1.tvalid : s0.tvalid;
  assign w_other_state = w_g0 ? ST_GNT1 : ST_GNT0;
  assign grant         = r_state;

  // State, last-served and in-packet registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_last_served <= 1'b1;
      r_in_packet   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_last_served <= w_last_served_next;
      r_in_packet   <= w_in_packet_next;
    end
  end

  // Arbitration: pick a source from IDLE, hand over directly at packet ends,
  // and release an idle grant only when its source has nothing on offer.
  always_comb begin
    w_state_next       = r_state;
    w_last_served_next = r_last_served;
    w_in_packet_next   = r_in_packet;
    case (r_state)
      ST_IDLE: begin
        if (s0.tvalid && s1.tvalid) begin
          w_state_next = r_last_served ? ST_GNT0 : ST_GNT1;
        end else if (s0.tvalid) begin
          w_state_next = ST_GNT0;
        end else if (s1.tvalid) begin
          w_state_next = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (w_eop) begin
          w_in_packet_next   = 1'b0;
          w_last_served_next = w_g1;
          if (w_oth_valid) begin
            w_state_next = w_other_state;
          end else if (!w_cur_valid) begin
            w_state_next = ST_IDLE;
          end
        end else if (w_accept) begin
          w_in_packet_next = 1'b1;
        end else if (!r_in_packet && !w_cur_valid) begin
          // Between packets and the owner has nothing pending: let go.
          w_state_next = w_oth_valid ? w_other_state : ST_IDLE;
        end
      end
      default: begin
        w_state_next     = ST_IDLE;
        w_in_packet_next = 1'b0;
      end
    endcase
  end

  // Mid-packet stall supervision; a zero timeout removes the logic entirely.
  generate
    if (STALL_TIMEOUT > 0) begin : gen_stall
      localparam int STALL_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT + 1) : 1;
      logic [STALL_W-1:0] r_stall_cnt;
      logic               r_stall_error;
      logic               w_stalling;

      assign w_stalling = r_in_packet & (w_g0 | w_g1) & ~w_cur_valid;

      // Count consecutive empty cycles inside a packet; flag once the limit is hit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_stall_cnt   <= '0;
          r_stall_error <= 1'b0;
        end else begin
          if (!w_stalling) begin
            r_stall_cnt <= '0;
          end else if (r_stall_cnt != STALL_W'(STALL_TIMEOUT)) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
          end
          if (clear_stats) begin
            r_stall_error <= 1'b0;
          end else if (w_stalling && (r_stall_cnt >= STALL_W'(STALL_TIMEOUT - 1))) begin
            r_stall_error <= 1'b1;
          end
        end
      end
      assign stall_error = r_stall_error;
    end else begin : gen_no_stall
      assign stall_error = 1'b0;
    end
  endgenerate

  // Per-source accepted beat / accepted tlast strobes.
  logic [1:0] w_acc;
  logic [1:0] w_acc_last;
  assign w_acc      = {w_g1 & w_accept, w_g0 & w_accept};
  assign w_acc_last = w_acc & {2{m.tlast}};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_stats
      logic [CNT_WIDTH-1:0] r_beats;
      logic [CNT_WIDTH-1:0] r_pkts;

      // Saturating statistics; a clear in the same cycle as a beat wins.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_beats <= '0;
          r_pkts  <= '0;
        end else if (clear_stats) begin
          r_beats <= '0;
          r_pkts  <= '0;
        end else begin
          if (w_acc[gi] && (r_beats != '1)) begin
            r_beats <= r_beats + CNT_WIDTH'(1);
          end
          if (w_acc_last[gi] && (r_pkts != '1)) begin
            r_pkts <= r_pkts + CNT_WIDTH'(1);
          end
        end
      end
    end
  endgenerate

  assign beats0 = gen_stats[0].r_beats;
  assign beats1 = gen_stats[1].r_beats;
  assign pkts0  = gen_stats[0].r_pkts;
  assign pkts1  = gen_stats[1].r_pkts;

endmodule
